// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, load/store opcodes and
// default addresses, imported by the sequencer and the control block.
package cpu_pkg;

   localparam int          CPU_STATE_W          = 3;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

   typedef enum logic [CPU_STATE_W-1:0] {
      ST_FETCH  = 3'd0,
      ST_MEM    = 3'd1,
      ST_EXEC   = 3'd2,
      ST_HALTED = 3'd3
   } cpu_state_t;

   localparam logic [5:0] OP_LB  = 6'd32;
   localparam logic [5:0] OP_LH  = 6'd33;
   localparam logic [5:0] OP_LWL = 6'd34;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_LBU = 6'd36;
   localparam logic [5:0] OP_LHU = 6'd37;
   localparam logic [5:0] OP_LWR = 6'd38;
   localparam logic [5:0] OP_SB  = 6'd40;
   localparam logic [5:0] OP_SH  = 6'd41;
   localparam logic [5:0] OP_SW  = 6'd43;

   // True for every opcode that needs a data-bus transfer after EXEC.
   function automatic logic is_ldst(input logic [5:0] op);
      case (op)
         OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
         OP_SB, OP_SH, OP_SW: is_ldst = 1'b1;
         default:             is_ldst = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_state_sequencer.sv
// Multicycle FETCH/EXEC/MEM sequencer feeding the control block. Stalls on
// waitrequest, latches the instruction, strobes ir_wren/pc_wren/ldst_done,
// counts retired instructions and halts when the next PC is HALT_ADDR.
// All outputs are registered; strobes appear in the cycle the new state does.
module cpu_state_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] HALT_ADDR = DEFAULT_HALT_ADDR,
   parameter int          STATE_W   = CPU_STATE_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               waitrequest,
   input  logic [31:0]        readdata,
   input  logic [31:0]        pc_next,
   output logic [STATE_W-1:0] state,
   output logic [31:0]        ir,
   output logic [5:0]         opcode,
   output logic [5:0]         function_code,
   output logic [4:0]         b_code,
   output logic               ir_wren,
   output logic               pc_wren,
   output logic               ldst_done,
   output logic               active,
   output logic [31:0]        instr_count
);

   cpu_state_t  state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] count_q, count_d;
   logic        active_q, active_d;
   logic        ir_wren_d, pc_wren_d, ldst_done_d;
   logic        retire;

   // Next-state and next-output decode for the whole sequencer.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d     = state_q;
      ir_d        = ir_q;
      count_d     = count_q;
      active_d    = active_q;
      ir_wren_d   = 1'b0;
      pc_wren_d   = 1'b0;
      ldst_done_d = 1'b0;
      retire      = 1'b0;

      case (state_q)
         ST_FETCH: begin
            if (!waitrequest) begin
               ir_d      = readdata;
               ir_wren_d = 1'b1;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (is_ldst(ir_q[31:26])) state_d = ST_MEM;
            else                      retire  = 1'b1;
         end
         ST_MEM: begin
            if (!waitrequest) begin
               ldst_done_d = 1'b1;
               retire      = 1'b1;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            // Unreachable encodings recover to FETCH, leaving active alone.
            state_d = ST_FETCH;
         end
      endcase

      // Halt is decided only when an instruction retires.
      if (retire) begin
         pc_wren_d = 1'b1;
         count_d   = count_q + 32'd1;
         if (pc_next == HALT_ADDR) begin
            state_d  = ST_HALTED;
            active_d = 1'b0;
         end else begin
            state_d  = ST_FETCH;
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      if (!reset_n) begin
         state_q     <= ST_FETCH;
         ir_q        <= 32'd0;
         count_q     <= 32'd0;
         active_q    <= 1'b1;
         ir_wren     <= 1'b0;
         pc_wren     <= 1'b0;
         ldst_done   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         count_q     <= count_d;
         active_q    <= active_d;
         ir_wren     <= ir_wren_d;
         pc_wren     <= pc_wren_d;
         ldst_done   <= ldst_done_d;
      end
   end

   assign state         = STATE_W'(state_q);
   assign ir            = ir_q;
   assign opcode        = ir_q[31:26];
   assign function_code = ir_q[5:0];
   assign b_code        = ir_q[20:16];
   assign active        = active_q;
   assign instr_count   = count_q;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Self-checking bench for cpu_state_sequencer: directed scenarios followed by
// randomized bus traffic, compared every cycle against a behavioural model.
module tb_cpu_state_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        waitrequest;
   logic [31:0] readdata;
   logic [31:0] pc_next;
   logic [2:0]  state;
   logic [31:0] ir;
   logic [5:0]  opcode;
   logic [5:0]  function_code;
   logic [4:0]  b_code;
   logic        ir_wren, pc_wren, ldst_done, active;
   logic [31:0] instr_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   cpu_state_sequencer dut (
      .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest),
      .readdata(readdata), .pc_next(pc_next), .state(state), .ir(ir),
      .opcode(opcode), .function_code(function_code), .b_code(b_code),
      .ir_wren(ir_wren), .pc_wren(pc_wren), .ldst_done(ldst_done),
      .active(active), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase names as plain numbers from the state table.
   int          m_state  = 0;  // 0 fetch, 1 mem, 2 exec, 3 halted
   logic [31:0] m_ir     = 0;
   logic [31:0] m_count  = 0;
   bit          m_active = 1;
   bit          m_irw = 0, m_pcw = 0, m_ldd = 0;
   int          ldst_ops [10] = '{32, 33, 34, 35, 36, 37, 38, 40, 41, 43};

   function automatic bit model_is_ldst(input logic [31:0] word);
      int op = int'(word[31:26]);
      foreach (ldst_ops[i]) if (ldst_ops[i] == op) return 1;
      return 0;
   endfunction

   task automatic model_retire();
      m_pcw   = 1;
      m_count = m_count + 1;
      if (pc_next == 32'h0) begin
         m_state  = 3;
         m_active = 0;
      end else begin
         m_state = 0;
      end
   endtask

   // Model advance on every rising edge from the inputs the DUT sees.
   always @(posedge clk) begin
      if (!reset_n) begin
         m_state = 0; m_ir = 0; m_count = 0; m_active = 1;
         m_irw = 0; m_pcw = 0; m_ldd = 0;
      end else begin
         m_irw = 0; m_pcw = 0; m_ldd = 0;
         if (m_state == 0) begin
            if (!waitrequest) begin m_ir = readdata; m_irw = 1; m_state = 2; end
         end else if (m_state == 2) begin
            if (model_is_ldst(m_ir)) m_state = 1;
            else                     model_retire();
         end else if (m_state == 1) begin
            if (!waitrequest) begin m_ldd = 1; model_retire(); end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("state",       32'(state),         32'(m_state));
         check("ir",          ir,                 m_ir);
         check("opcode",      32'(opcode),        32'(m_ir[31:26]));
         check("funct",       32'(function_code), 32'(m_ir[5:0]));
         check("b_code",      32'(b_code),        32'(m_ir[20:16]));
         check("ir_wren",     32'(ir_wren),       32'(m_irw));
         check("pc_wren",     32'(pc_wren),       32'(m_pcw));
         check("ldst_done",   32'(ldst_done),     32'(m_ldd));
         check("active",      32'(active),        32'(m_active));
         check("instr_count", instr_count,        m_count);
      end
   end

   // Apply inputs now (at a falling edge) and return at the next falling edge.
   task automatic step(input bit wr, input logic [31:0] rd, input logic [31:0] pcn, input bit rn);
      waitrequest = wr;
      readdata    = rd;
      pc_next     = pcn;
      reset_n     = rn;
      @(negedge clk);
   endtask

   task automatic do_reset();
      step(1'b0, 32'h0, 32'h4, 1'b0);
   endtask

   localparam logic [31:0] ADDU  = 32'h0085_1021;
   localparam logic [31:0] LW    = 32'h8C82_0004;
   localparam logic [31:0] ADDIU = 32'h2402_0005;
   localparam logic [31:0] JR    = 32'h03E0_0008;
   localparam logic [31:0] SW    = 32'hAC82_0008;

   initial begin
      logic [31:0] rd;
      reset_n = 0; waitrequest = 0; readdata = 0; pc_next = 32'h4;
      @(negedge clk);
      do_reset();
      chk_en = 1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_active", 32'(active), 32'd1);
      check("rst_count", instr_count, 32'd0);

      // ADDU, zero-wait bus.
      step(0, ADDU, 32'hBFC0_0004, 1);
      check("addu_exec", 32'(state), 32'd2);
      check("addu_irw", 32'(ir_wren), 32'd1);
      check("addu_op", 32'(opcode), 32'd0);
      check("addu_fn", 32'(function_code), 32'd33);
      step(1, 32'h0, 32'hBFC0_0008, 1);
      check("addu_fetch", 32'(state), 32'd0);
      check("addu_pcw", 32'(pc_wren), 32'd1);
      check("addu_cnt", instr_count, 32'd1);
      check("model_cnt", m_count, 32'd1);

      // LW with a three-cycle MEM stall.
      do_reset();
      step(0, LW, 32'h10, 1);
      check("lw_exec", 32'(state), 32'd2);
      step(1, 32'h0, 32'h10, 1);
      check("lw_mem", 32'(state), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h0, 32'h10, 1);
         check("lw_stall", 32'(state), 32'd1);
         check("lw_stall_ldd", 32'(ldst_done), 32'd0);
      end
      step(0, 32'h0, 32'h10, 1);
      check("lw_done_state", 32'(state), 32'd0);
      check("lw_ldd", 32'(ldst_done), 32'd1);
      check("lw_pcw", 32'(pc_wren), 32'd1);
      check("lw_cnt", instr_count, 32'd1);

      // FETCH stall with junk data on the bus.
      for (int i = 0; i < 5; i++) begin
         step(1, 32'hDEAD_BEEF, 32'h14, 1);
         check("fstall_irw", 32'(ir_wren), 32'd0);
      end
      step(0, ADDIU, 32'h14, 1);
      check("fetch_ir", ir, ADDIU);
      check("fetch_irw", 32'(ir_wren), 32'd1);
      step(0, 32'h0, 32'h18, 1);

      // JR retiring to address 0 halts.
      step(0, JR, 32'h1C, 1);
      step(0, 32'h0, 32'h0, 1);
      check("jr_halt", 32'(state), 32'd3);
      check("jr_active", 32'(active), 32'd0);
      check("model_halt", 32'(m_state), 32'd3);
      for (int i = 0; i < 20; i++) begin
         step(1'($urandom_range(0, 1)), $urandom, $urandom, 1);
         check("halt_irw", 32'(ir_wren), 32'd0);
      end
      check("halt_ir", ir, JR);

      // Reset in the middle of a MEM stall.
      do_reset();
      step(0, LW, 32'h10, 1);
      step(1, 32'h0, 32'h10, 1);
      step(1, 32'h0, 32'h10, 1);
      step(1, 32'h0, 32'h10, 0);
      check("mrst_state", 32'(state), 32'd0);
      check("mrst_ir", ir, 32'd0);
      check("mrst_active", 32'(active), 32'd1);
      check("mrst_ldd", 32'(ldst_done), 32'd0);

      // SW retiring to address 0 from MEM.
      step(0, SW, 32'h10, 1);
      step(0, 32'h0, 32'h10, 1);
      step(0, 32'h0, 32'h0, 1);
      check("sw_ldd", 32'(ldst_done), 32'd1);
      check("sw_pcw", 32'(pc_wren), 32'd1);
      check("sw_halt", 32'(state), 32'd3);

      // Randomized traffic with occasional resets and halts.
      for (int i = 0; i < 3000; i++) begin
         bit rn;
         rd = $urandom;
         if ($urandom_range(0, 1) == 0)
            rd[31:26] = 6'(ldst_ops[$urandom_range(0, 9)]);
         rn = !(($urandom_range(0, 199) == 0) ||
                (m_state == 3 && $urandom_range(0, 4) == 0));
         step(1'($urandom_range(0, 2) == 0), rd,
              ($urandom_range(0, 29) == 0) ? 32'h0 : ($urandom | 32'h4), rn);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_state_sequencer.md
Name: cpu_state_sequencer

Overview:
- Multicycle sequencer directly upstream of the instruction decoder/control block.
- Generates the 3-bit `state` (FETCH/MEM/EXEC) that the control block consumes, stalls on bus `waitrequest`, latches the fetched instruction and presents its fields (`opcode`, `function_code`, `b_code`) to control.
- Issues `pc_wren` and `ir_wren` strobes, detects the halt condition and drives `active`.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value the design starts from (informational; the PC register owns the value).
- HALT_ADDR, 32'h00000000, next-PC value that causes a halt at instruction retire.
- STATE_W, 3, width of the `state` output.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- waitrequest  in  1  bus stall; current transfer not yet complete while high
- readdata  in  32  bus read data; instruction word in FETCH
- pc_next  in  32  value the PC register will take when `pc_wren` is high
- state  out  STATE_W  0=FETCH, 1=MEM, 2=EXEC, 3=HALTED
- ir  out  32  latched instruction register
- opcode  out  6  ir[31:26]
- function_code  out  6  ir[5:0]
- b_code  out  5  ir[20:16]
- ir_wren  out  1  one-cycle pulse when the instruction is captured
- pc_wren  out  1  one-cycle pulse when the instruction retires
- ldst_done  out  1  one-cycle pulse when a MEM transfer completes (load data valid)
- active  out  1  high while executing; low once halted
- instr_count  out  32  retired-instruction counter

Behaviour:
- Reset (`reset_n`=0 at a clock edge), applied from any state including mid-MEM or HALTED:
  - state=FETCH, ir=0, active=1, instr_count=0.
  - ir_wren=pc_wren=ldst_done=0.
- All outputs are registered except the field slices of `ir`.
- FETCH:
  - While waitrequest=1, hold FETCH with no strobes.
  - On waitrequest=0: ir<=readdata, ir_wren=1 for that cycle, next state EXEC.
- EXEC: always exactly one cycle. Opcode is taken from the latched ir.
  - Opcode in {32..38, 40, 41, 43} (load/store): next state MEM, no pc_wren.
  - Otherwise: pc_wren=1 this cycle, instr_count+1, next state FETCH, or HALTED if pc_next==HALT_ADDR.
- MEM:
  - While waitrequest=1, hold MEM.
  - On waitrequest=0: ldst_done=1 and pc_wren=1 in the same cycle, instr_count+1, next state FETCH, or HALTED if pc_next==HALT_ADDR.
- HALTED:
  - Terminal until reset; active=0 from the first HALTED cycle.
  - No strobes; ir and instr_count frozen.
- Halt decision is taken at retire, never in FETCH, so no fetch is issued from HALT_ADDR.
- waitrequest is ignored in EXEC and HALTED.
- waitrequest is sampled only in FETCH and MEM. A waitrequest high on entry stalls for the full duration; a zero-wait bus completes in one cycle.
- Latency: non-memory instruction is 2 cycles minimum (FETCH+EXEC); load/store is 3 cycles minimum.
- instr_count wraps modulo 2^32 with no flag.
- Unused encodings 4..7 of `state` are unreachable. If reached, the next state is FETCH with active unchanged.
- `state` must never change in a cycle in which a stalled transfer is still pending.

Decomposition:
- Shared package `cpu_pkg`:
  - state enum (FETCH=0, MEM=1, EXEC=2, HALTED=3), width STATE_W.
  - load/store opcode constants (LB=32 … LWR=38, SB=40, SH=41, SW=43).
  - RESET_VECTOR and HALT_ADDR defaults.
- The control block is to import the same state constants.
- No sub-module needed; the load/store classifier is a package function `is_ldst(opcode)`.

Test Plan:
- Reset, then ADDU (readdata=32'h00851021) with waitrequest=0 → state 0,2,0; ir_wren on cycle 1, pc_wren on cycle 2; opcode=0, function_code=33; instr_count=1.
- LW (32'h8C820004), waitrequest held high 3 cycles in MEM → state 0,2,1,1,1,1,0; ldst_done and pc_wren both high only on the last MEM cycle; instr_count=1.
- FETCH with waitrequest high 5 cycles, readdata=32'hDEADBEEF during the stall then 32'h24020005 on release → ir=32'h24020005, ir_wren pulses once.
- JR retiring with pc_next=0 → state HALTED next cycle, active=0, no further ir_wren under arbitrary readdata/waitrequest for 20 cycles.
- reset_n low during MEM stall → next cycle state=FETCH, ir=0, active=1, instr_count=0, no ldst_done.
- SW (32'hAC820008) retiring with pc_next=0 from MEM → ldst_done=1 and pc_wren=1 in the same cycle, then HALTED.
